// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and constants for the cache memory arbiter
// Holds the arbiter FSM state encoding, the requester identifiers and the
// default line length in beats that the cache controllers are also built around.
package cache_arb_pkg;

    // Words per cache line; one memory burst moves exactly one line.
    localparam int CACHE_BURST_LEN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // The numeric value doubles as the bit index into the {dc, ic} request vector.
    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin requester picker
// Ports:
//   req   in  [1:0]    request vector, bit 0 = icache, bit 1 = dcache
//   last  in  req_id_t requester that owned the previous completed burst
//   grant out req_id_t requester to serve next (only meaningful when |req)
module rr_arb2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output req_id_t    grant
);

    always_comb begin
        grant = REQ_IC;
        if (req == 2'b11) begin
            // Contention: hand the port to whoever did not have it last time.
            if (last == REQ_IC) begin
                grant = REQ_DC;
            end else begin
                grant = REQ_IC;
            end
        end else if (req[1]) begin
            grant = REQ_DC;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one burst memory port between icache and dcache
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   ic_req/ic_addr                  icache line-fill request and line base address
//   ic_addr_ok/ic_data_ok/ic_rdata  icache address accept, read beat strobe, read beat
//   dc_req/dc_wr/dc_addr/dc_wdata   dcache request, direction (1 = writeback), address, write beat
//   dc_addr_ok/dc_data_ok/dc_rdata  dcache address accept, beat strobe, read beat
//   mem_req/mem_wr/mem_addr         burst request, direction and base address to the bridge
//   mem_wdata/mem_wlast             write beat and final-beat marker to the bridge
//   mem_addr_ok/mem_data_ok/mem_rdata  bridge address accept, beat handshake, read beat
//   busy                            a burst is in progress
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int BURST_LEN = CACHE_BURST_LEN,
    parameter int CNT_W     = $clog2(BURST_LEN) + 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_addr_ok,
    output logic        ic_data_ok,
    output logic [31:0] ic_rdata,
    input  logic        dc_req,
    input  logic        dc_wr,
    input  logic [31:0] dc_addr,
    input  logic [31:0] dc_wdata,
    output logic        dc_addr_ok,
    output logic        dc_data_ok,
    output logic [31:0] dc_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wlast,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t        state_q, state_d;
    req_id_t           grant_q, grant_d;
    req_id_t           last_grant_q, last_grant_d;
    req_id_t           pick;
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic addr_hs;
    logic data_hs;
    logic last_beat;

    rr_arb2 u_rr_arb2 (
        .req   ({dc_req, ic_req}),
        .last  (last_grant_q),
        .grant (pick)
    );

    // Handshakes only count in the phase they belong to; a beat strobe seen
    // while still waiting for address acceptance is dropped.
    assign addr_hs   = (state_q == ADDR) && mem_addr_ok;
    assign data_hs   = (state_q == DATA) && mem_data_ok;
    assign last_beat = (cnt_q == LAST_BEAT);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    grant_d   = pick;
                    mem_req_d = 1'b1;
                    if (pick == REQ_DC) begin
                        mem_addr_d = dc_addr;
                        mem_wr_d   = dc_wr;
                    end else begin
                        mem_addr_d = ic_addr;
                        mem_wr_d   = 1'b0;
                    end
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    if (last_beat) begin
                        // The fairness pointer only moves once a burst is fully done.
                        last_grant_d = grant_q;
                        cnt_d        = '0;
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= REQ_IC;
            last_grant_q <= REQ_IC;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = dc_wdata;
    assign mem_wlast  = (state_q == DATA) && mem_wr_q && last_beat;

    assign ic_addr_ok = addr_hs && (grant_q == REQ_IC);
    assign dc_addr_ok = addr_hs && (grant_q == REQ_DC);
    assign ic_data_ok = data_hs && (grant_q == REQ_IC);
    assign dc_data_ok = data_hs && (grant_q == REQ_DC);

    // Read data fans out unconditionally; only the strobes say who owns it.
    assign ic_rdata   = mem_rdata;
    assign dc_rdata   = mem_rdata;

    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    localparam int BL = CACHE_BURST_LEN;

    logic        clk;
    logic        resetn;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_addr_ok;
    logic        ic_data_ok;
    logic [31:0] ic_rdata;
    logic        dc_req;
    logic        dc_wr;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_addr_ok;
    logic        dc_data_ok;
    logic [31:0] dc_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wlast;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    cache_mem_arbiter #(.BURST_LEN(BL)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .ic_addr_ok  (ic_addr_ok),
        .ic_data_ok  (ic_data_ok),
        .ic_rdata    (ic_rdata),
        .dc_req      (dc_req),
        .dc_wr       (dc_wr),
        .dc_addr     (dc_addr),
        .dc_wdata    (dc_wdata),
        .dc_addr_ok  (dc_addr_ok),
        .dc_data_ok  (dc_data_ok),
        .dc_rdata    (dc_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wlast   (mem_wlast),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state: 0 = icache owned the last finished burst, 1 = dcache.
    int model_last = 0;

    logic [31:0] wb_words [BL];

    int          obs_req_cycles, obs_ic_aok, obs_dc_aok, obs_ic_dok, obs_dc_dok;
    int          obs_spur_fwd, obs_grant, obs_wait;
    bit          obs_timeout, obs_busy_after;
    logic [31:0] obs_addr;
    logic        obs_wr;
    logic [31:0] obs_rd_ic [BL];
    logic [31:0] obs_rd_dc [BL];
    logic [31:0] obs_wd    [BL];
    logic        obs_wl    [BL];

    function automatic int model_pick(input bit ic, input bit dc, input int last);
        if (ic && dc) return 1 - last;
        return dc ? 1 : 0;
    endfunction

    task automatic sample_strobes();
        obs_ic_aok += int'(ic_addr_ok);
        obs_dc_aok += int'(dc_addr_ok);
        obs_ic_dok += int'(ic_data_ok);
        obs_dc_dok += int'(dc_data_ok);
    endtask

    // Plays the bridge for one burst: accepts the address on the addr_wait-th
    // cycle of mem_req, then returns BL beats with random gaps, recording what
    // the arbiter presented. Drops the granted request after addr_ok unless hold.
    task automatic serve_burst(input int addr_wait, input bit spurious, input bit hold,
                               input logic [31:0] rbase);
        int guard;
        int beat;
        bit do_beat;
        obs_timeout = 0; obs_req_cycles = 0; obs_ic_aok = 0; obs_dc_aok = 0;
        obs_ic_dok = 0; obs_dc_dok = 0; obs_spur_fwd = 0; obs_grant = -1;
        obs_busy_after = 1'b1; obs_addr = '0; obs_wr = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!mem_req && guard < 50) begin
            #1 sample_strobes();
            guard++;
            @(negedge clk);
        end
        obs_wait = guard;
        if (!mem_req) begin
            obs_timeout = 1;
            return;
        end
        for (int c = 1; c <= addr_wait; c++) begin
            if (mem_req) obs_req_cycles++;
            if (c == addr_wait) begin
                mem_addr_ok = 1'b1;
            end else if (spurious && c == 1) begin
                mem_data_ok = 1'b1;
                mem_rdata   = 32'hdead_beef;
            end
            #1;
            if (spurious && c == 1 && c != addr_wait && (ic_data_ok || dc_data_ok)) obs_spur_fwd++;
            if (c == addr_wait) begin
                obs_addr  = mem_addr;
                obs_wr    = mem_wr;
                obs_grant = ic_addr_ok ? 0 : (dc_addr_ok ? 1 : -1);
            end
            sample_strobes();
            @(negedge clk);
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
        end
        if (!hold) begin
            if (obs_grant == 0) ic_req = 1'b0;
            if (obs_grant == 1) dc_req = 1'b0;
        end
        beat  = 0;
        guard = 0;
        while (beat < BL && guard < 200) begin
            guard++;
            dc_wdata = wb_words[beat];
            do_beat  = ($urandom_range(0, 3) != 0);
            if (do_beat) begin
                mem_data_ok = 1'b1;
                mem_rdata   = rbase + 32'(beat);
            end
            #1;
            if (mem_req) obs_req_cycles++;
            sample_strobes();
            if (do_beat) begin
                obs_rd_ic[beat] = ic_rdata;
                obs_rd_dc[beat] = dc_rdata;
                obs_wd[beat]    = mem_wdata;
                obs_wl[beat]    = mem_wlast;
                beat++;
            end
            @(negedge clk);
            mem_data_ok = 1'b0;
        end
        if (beat < BL) obs_timeout = 1;
        #1;
        obs_busy_after = busy;
        sample_strobes();
    endtask

    task automatic test_reset();
        resetn = 1'b0; ic_req = 1'b1; dc_req = 1'b1; dc_wr = 1'b1;
        ic_addr = 32'h0000_1100; dc_addr = 32'h0000_2200; dc_wdata = '0;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        checks_total++;
        if (mem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_idle: mem_req=%b busy=%b want 0 0", mem_req, busy);
        else checks_passed++;
        checks_total++;
        if (mem_wr !== 1'b0 || mem_addr !== 32'h0)
            $display("FAIL reset_regs: mem_wr=%b mem_addr=%h want 0 0", mem_wr, mem_addr);
        else checks_passed++;
        checks_total++;
        if ({ic_addr_ok, ic_data_ok, dc_addr_ok, dc_data_ok, mem_wlast} !== 5'b0)
            $display("FAIL reset_strobes: got %b want 00000",
                     {ic_addr_ok, ic_data_ok, dc_addr_ok, dc_data_ok, mem_wlast});
        else checks_passed++;
        ic_req = 1'b0; dc_req = 1'b0; dc_wr = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_last = 0;
        @(negedge clk);
        #1;
        checks_total++;
        if (mem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_release_idle: mem_req=%b busy=%b want 0 0", mem_req, busy);
        else checks_passed++;
    endtask

    task automatic test_ic_fill();
        logic [31:0] rbase;
        int exp_grant;
        rbase = $urandom;
        for (int i = 0; i < BL; i++) wb_words[i] = $urandom;
        ic_addr = {$urandom_range(0, 32'h0fff_ffff), 4'h0} & 32'hffff_ffe0;
        exp_grant = model_pick(1'b1, 1'b0, model_last);
        ic_req = 1'b1;
        serve_burst(3, 1'b0, 1'b0, rbase);
        checks_total++;
        if (obs_timeout) $display("FAIL ic_fill_timeout: burst did not complete");
        else checks_passed++;
        checks_total++;
        if (obs_req_cycles !== 3)
            $display("FAIL ic_fill_req_cycles: got %0d want 3", obs_req_cycles);
        else checks_passed++;
        checks_total++;
        if (obs_grant !== exp_grant || obs_ic_aok !== 1 || obs_dc_aok !== 0)
            $display("FAIL ic_fill_addr_ok: grant=%0d ic=%0d dc=%0d want %0d 1 0",
                     obs_grant, obs_ic_aok, obs_dc_aok, exp_grant);
        else checks_passed++;
        checks_total++;
        if (obs_addr !== ic_addr || obs_wr !== 1'b0)
            $display("FAIL ic_fill_addr: addr=%h wr=%b want %h 0", obs_addr, obs_wr, ic_addr);
        else checks_passed++;
        checks_total++;
        if (obs_ic_dok !== BL || obs_dc_dok !== 0)
            $display("FAIL ic_fill_beats: ic=%0d dc=%0d want %0d 0", obs_ic_dok, obs_dc_dok, BL);
        else checks_passed++;
        for (int i = 0; i < BL; i++) begin
            checks_total++;
            if (obs_rd_ic[i] !== rbase + 32'(i))
                $display("FAIL ic_fill_rdata[%0d]: got %h want %h", i, obs_rd_ic[i], rbase + 32'(i));
            else checks_passed++;
        end
        checks_total++;
        if (obs_busy_after !== 1'b0)
            $display("FAIL ic_fill_busy_after: got %b want 0", obs_busy_after);
        else checks_passed++;
        model_last = exp_grant;
    endtask

    task automatic test_dc_writeback();
        for (int i = 0; i < BL; i++) wb_words[i] = 32'(i);
        dc_addr = 32'h1000_0040; dc_wr = 1'b1; dc_req = 1'b1;
        serve_burst($urandom_range(1, 4), 1'b0, 1'b0, $urandom);
        checks_total++;
        if (obs_timeout) $display("FAIL wb_timeout: burst did not complete");
        else checks_passed++;
        checks_total++;
        if (obs_grant !== model_pick(1'b0, 1'b1, model_last) || obs_wr !== 1'b1 || obs_addr !== 32'h1000_0040)
            $display("FAIL wb_grant: grant=%0d wr=%b addr=%h want 1 1 10000040", obs_grant, obs_wr, obs_addr);
        else checks_passed++;
        for (int i = 0; i < BL; i++) begin
            checks_total++;
            if (obs_wd[i] !== wb_words[i] || obs_wl[i] !== (i == BL - 1))
                $display("FAIL wb_beat[%0d]: wdata=%h wlast=%b want %h %b",
                         i, obs_wd[i], obs_wl[i], wb_words[i], (i == BL - 1));
            else checks_passed++;
        end
        checks_total++;
        if (obs_dc_dok !== BL || obs_ic_dok !== 0 || obs_ic_aok !== 0)
            $display("FAIL wb_strobes: dc_data=%0d ic_data=%0d ic_addr=%0d want %0d 0 0",
                     obs_dc_dok, obs_ic_dok, obs_ic_aok, BL);
        else checks_passed++;
        dc_wr = 1'b0;
        model_last = 1;
    endtask

    task automatic test_wb_then_refill();
        logic [31:0] line;
        logic [31:0] rbase;
        bit          wlast_seen;
        line = {$urandom_range(0, 32'h07ff_ffff), 5'h0};
        for (int i = 0; i < BL; i++) wb_words[i] = $urandom;
        dc_addr = line; dc_wr = 1'b1; dc_req = 1'b1;
        serve_burst($urandom_range(1, 3), 1'b0, 1'b0, $urandom);
        wlast_seen = obs_wl[BL-1];
        checks_total++;
        if (obs_timeout || !wlast_seen || obs_busy_after !== 1'b0)
            $display("FAIL wbr_write_done: timeout=%b wlast=%b busy=%b want 0 1 0",
                     obs_timeout, wlast_seen, obs_busy_after);
        else checks_passed++;
        checks_total++;
        if (obs_req_cycles < 1 || mem_req !== 1'b0)
            $display("FAIL wbr_no_early_read: req_cycles=%0d mem_req=%b want >=1 0", obs_req_cycles, mem_req);
        else checks_passed++;
        model_last = 1;
        dc_wr = 1'b0; dc_req = 1'b1;
        rbase = $urandom;
        serve_burst($urandom_range(1, 3), 1'b0, 1'b0, rbase);
        checks_total++;
        if (obs_timeout || obs_grant !== model_pick(1'b0, 1'b1, model_last) || obs_wr !== 1'b0 || obs_addr !== line)
            $display("FAIL wbr_read_grant: timeout=%b grant=%0d wr=%b addr=%h want 0 1 0 %h",
                     obs_timeout, obs_grant, obs_wr, obs_addr, line);
        else checks_passed++;
        checks_total++;
        if (obs_dc_dok !== BL || obs_ic_dok !== 0)
            $display("FAIL wbr_read_routing: dc=%0d ic=%0d want %0d 0", obs_dc_dok, obs_ic_dok, BL);
        else checks_passed++;
        for (int i = 0; i < BL; i++) begin
            checks_total++;
            if (obs_rd_dc[i] !== rbase + 32'(i))
                $display("FAIL wbr_rdata[%0d]: got %h want %h", i, obs_rd_dc[i], rbase + 32'(i));
            else checks_passed++;
        end
        model_last = 1;
    endtask

    task automatic test_round_robin();
        int exp_grant;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_last = 0;
        ic_addr = 32'h0000_0a00; dc_addr = 32'h0000_0b00; dc_wr = 1'b0;
        ic_req = 1'b1; dc_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_grant = model_pick(1'b1, 1'b1, model_last);
            serve_burst($urandom_range(1, 3), 1'b0, 1'b1, $urandom);
            checks_total++;
            if (obs_timeout || obs_grant !== exp_grant)
                $display("FAIL rr_grant[%0d]: timeout=%b grant=%0d want %0d", n, obs_timeout, obs_grant, exp_grant);
            else checks_passed++;
            checks_total++;
            if (obs_wait !== 0)
                $display("FAIL rr_regrant_latency[%0d]: waited %0d cycles want 0", n, obs_wait);
            else checks_passed++;
            checks_total++;
            if ((exp_grant == 0 && (obs_ic_dok !== BL || obs_dc_dok !== 0 || obs_dc_aok !== 0)) ||
                (exp_grant == 1 && (obs_dc_dok !== BL || obs_ic_dok !== 0 || obs_ic_aok !== 0)))
                $display("FAIL rr_routing[%0d]: ic_data=%0d dc_data=%0d ic_addr=%0d dc_addr=%0d grantee %0d",
                         n, obs_ic_dok, obs_dc_dok, obs_ic_aok, obs_dc_aok, exp_grant);
            else checks_passed++;
            model_last = exp_grant;
        end
        ic_req = 1'b0; dc_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int tries;
        logic [31:0] new_addr;
        ic_addr = 32'h0000_3300; ic_req = 1'b1;
        @(negedge clk);
        tries = 0;
        while (!mem_req && tries < 20) begin
            tries++;
            @(negedge clk);
        end
        checks_total++;
        if (mem_req !== 1'b1) $display("FAIL mid_grant: mem_req=%b want 1", mem_req);
        else checks_passed++;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0; ic_req = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_data_ok = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
        end
        mem_data_ok = 1'b1;
        #1 resetn = 1'b0;
        #1;
        checks_total++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0)
            $display("FAIL mid_reset_async: busy=%b mem_req=%b addr=%h want 0 0 0", busy, mem_req, mem_addr);
        else checks_passed++;
        checks_total++;
        if (ic_data_ok !== 1'b0 || dc_data_ok !== 1'b0)
            $display("FAIL mid_reset_no_data_ok: ic=%b dc=%b want 0 0", ic_data_ok, dc_data_ok);
        else checks_passed++;
        @(negedge clk);
        #1;
        checks_total++;
        if (ic_data_ok !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_reset_held: ic_data_ok=%b busy=%b want 0 0", ic_data_ok, busy);
        else checks_passed++;
        mem_data_ok = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_last = 0;
        new_addr = {$urandom_range(0, 32'h07ff_ffff), 5'h0};
        ic_addr = new_addr; ic_req = 1'b1;
        serve_burst(2, 1'b0, 1'b0, $urandom);
        checks_total++;
        if (obs_timeout || obs_grant !== 0 || obs_addr !== new_addr)
            $display("FAIL mid_after_grant: timeout=%b grant=%0d addr=%h want 0 0 %h",
                     obs_timeout, obs_grant, obs_addr, new_addr);
        else checks_passed++;
        checks_total++;
        if (obs_ic_dok !== BL || obs_busy_after !== 1'b0)
            $display("FAIL mid_after_beats: ic_data=%0d busy=%b want %0d 0", obs_ic_dok, obs_busy_after, BL);
        else checks_passed++;
        model_last = 0;
    endtask

    task automatic test_spurious_data_ok();
        logic [31:0] rbase;
        rbase = $urandom;
        dc_addr = 32'h0000_4400; dc_wr = 1'b0; dc_req = 1'b1;
        serve_burst(3, 1'b1, 1'b0, rbase);
        checks_total++;
        if (obs_spur_fwd !== 0)
            $display("FAIL spur_forwarded: got %0d strobes want 0", obs_spur_fwd);
        else checks_passed++;
        checks_total++;
        if (obs_timeout || obs_dc_dok !== BL || obs_ic_dok !== 0)
            $display("FAIL spur_beats: timeout=%b dc=%0d ic=%0d want 0 %0d 0",
                     obs_timeout, obs_dc_dok, obs_ic_dok, BL);
        else checks_passed++;
        checks_total++;
        if (obs_busy_after !== 1'b0)
            $display("FAIL spur_busy_after: got %b want 0", obs_busy_after);
        else checks_passed++;
        checks_total++;
        if (obs_rd_dc[BL-1] !== rbase + 32'(BL - 1))
            $display("FAIL spur_last_rdata: got %h want %h", obs_rd_dc[BL-1], rbase + 32'(BL - 1));
        else checks_passed++;
        model_last = 1;
    endtask

    initial begin
        test_reset();
        test_ic_fill();
        test_dc_writeback();
        test_wb_then_refill();
        test_round_robin();
        test_reset_mid_burst();
        test_spurious_data_ok();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
